pgm_deal_arbiter: RTL

Round-based dealer and arbiter for the card game datapath. It shares one pseudo-random card source among four player requesters using round-robin grants, and accumulates a hand per player. It flags busts and, at end of round, settles the winner and winning sum. It sits between the player request logic and the score/display outputs, and sequences START → deal → settle → done.

---
 rtl/pgm_deal_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pgm_deal_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : pgm_deal_arbiter
// Purpose  : Round-based card dealer. One free-running 16-bit Galois LFSR is
//            shared among four players through a round-robin arbiter. Each
//            grant deals one card (1..8) into the player's hand, and busts are
//            flagged. When the round closes, the unique best non-busted hand is
//            reported. Sequence: IDLE -> DEAL -> SETTLE -> DONE.
// Ports    : CLK, RESET (sync, active-high)
//            START      - pulse, opens a round from IDLE or DONE
//            STOP       - pulse, closes the round while dealing
//            REQ[3:0]   - per-player draw request (level)
//            GNT[3:0]   - one-hot grant, one cycle per card
//            GNT_ID     - granted player index, with CARD_VALID
//            CARD       - dealt card value, with CARD_VALID
//            CARD_VALID - card strobe, coincident with GNT
//            BUST[3:0]  - sticky per-round bust flags
//            OUT_VALID  - result valid (DONE state)
//            WIN        - {0,idx} for a unique winner, 3'b100 otherwise
//            SUM        - winning hand, 0 when there is no winner
// Options  : PGM_DECK_LIMIT_EN - when defined, limits a round to DECK_SIZE
//            cards and then closes the round automatically.
// Revision : 1.0 - initial release
//==============================================================================
module pgm_deal_arbiter #(
    parameter int          MAXH      = 10,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          DECK_SIZE = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       STOP,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] GNT_ID,
    output logic [3:0] CARD,
    output logic       CARD_VALID,
    output logic [3:0] BUST,
    output logic       OUT_VALID,
    output logic [2:0] WIN,
    output logic [3:0] SUM
);

    localparam logic [4:0]  c_BUST_LIMIT = 5'(MAXH);
    localparam logic [15:0] c_LFSR_MASK  = 16'hB400;
    localparam logic [2:0]  c_NO_WIN     = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DEAL   = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state;
    logic [15:0] r_lfsr;
    logic [1:0]  r_rr_ptr;
    logic [4:0]  r_hand [4];

    logic [15:0] w_lfsr_next;
    logic [3:0]  w_card;
    logic [3:0]  w_eligible;
    logic        w_grant;
    logic [1:0]  w_gnt_idx;
    logic [4:0]  w_new_hand;
    logic [3:0]  w_bust_next;
    logic        w_end_deal;
    logic        w_deck_empty;
    logic [3:0]  w_max;
    logic [1:0]  w_max_idx;
    logic        w_any;
    logic        w_tie;
    logic [2:0]  w_win;
    logic [3:0]  w_sum;

`ifdef PGM_DECK_LIMIT_EN
    localparam logic [5:0] c_DECK = 6'(DECK_SIZE);
    logic [5:0] r_dealt;
    assign w_deck_empty = (r_dealt >= c_DECK);
`else
    assign w_deck_empty = 1'b0;
`endif

    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_LFSR_MASK) : (r_lfsr >> 1);
    assign w_card      = {1'b0, r_lfsr[2:0]} + 4'd1;

    // The player granted last cycle is excluded, so a requester has a cycle
    // to drop REQ after seeing its grant.
    assign w_eligible  = REQ & ~BUST & ~GNT & {4{~w_deck_empty}};
    assign w_grant     = |w_eligible;

    // Cyclic priority search starting at r_rr_ptr. Scanning offsets from high
    // to low lets the closest eligible index overwrite farther ones.
    always_comb begin
        w_gnt_idx = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (w_eligible[r_rr_ptr + 2'(k)]) begin
                w_gnt_idx = r_rr_ptr + 2'(k);
            end
        end
    end

    assign w_new_hand = r_hand[w_gnt_idx] + {1'b0, w_card};

    always_comb begin
        w_bust_next = BUST;
        if (w_grant) begin
            w_bust_next[w_gnt_idx] = (w_new_hand > c_BUST_LIMIT);
        end
    end

    assign w_end_deal = STOP | (&w_bust_next) | w_deck_empty;

    // Settlement over non-busted hands; these are all <= MAXH, so 4 bits hold
    // the maximum.
    always_comb begin
        w_max     = '0;
        w_max_idx = '0;
        w_any     = 1'b0;
        w_tie     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!BUST[i]) begin
                if (!w_any || (r_hand[i] > {1'b0, w_max})) begin
                    w_max     = r_hand[i][3:0];
                    w_max_idx = 2'(i);
                    w_any     = 1'b1;
                    w_tie     = 1'b0;
                end else if (r_hand[i] == {1'b0, w_max}) begin
                    w_tie = 1'b1;
                end
            end
        end
        if (!w_any || w_tie) begin
            w_win = c_NO_WIN;
            w_sum = '0;
        end else begin
            w_win = {1'b0, w_max_idx};
            w_sum = w_max;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_lfsr     <= SEED;
            r_rr_ptr   <= '0;
            for (int i = 0; i < 4; i++) r_hand[i] <= '0;
            GNT        <= '0;
            GNT_ID     <= '0;
            CARD       <= '0;
            CARD_VALID <= 1'b0;
            BUST       <= '0;
            OUT_VALID  <= 1'b0;
            WIN        <= c_NO_WIN;
            SUM        <= '0;
`ifdef PGM_DECK_LIMIT_EN
            r_dealt    <= '0;
`endif
        end else begin
            r_lfsr <= w_lfsr_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    GNT        <= '0;
                    CARD_VALID <= 1'b0;
                    if (START) begin
                        for (int i = 0; i < 4; i++) r_hand[i] <= '0;
                        BUST      <= '0;
                        OUT_VALID <= 1'b0;
                        WIN       <= c_NO_WIN;
                        SUM       <= '0;
`ifdef PGM_DECK_LIMIT_EN
                        r_dealt   <= '0;
`endif
                        r_state   <= S_DEAL;
                    end
                end
                S_DEAL: begin
                    if (w_grant) begin
                        GNT               <= 4'b0001 << w_gnt_idx;
                        GNT_ID            <= w_gnt_idx;
                        CARD              <= w_card;
                        CARD_VALID        <= 1'b1;
                        r_hand[w_gnt_idx] <= w_new_hand;
                        r_rr_ptr          <= w_gnt_idx + 2'd1;
                        BUST              <= w_bust_next;
`ifdef PGM_DECK_LIMIT_EN
                        r_dealt           <= r_dealt + 6'd1;
`endif
                    end else begin
                        GNT        <= '0;
                        CARD_VALID <= 1'b0;
                    end
                    if (w_end_deal) begin
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    GNT        <= '0;
                    CARD_VALID <= 1'b0;
                    WIN        <= w_win;
                    SUM        <= w_sum;
                    OUT_VALID  <= 1'b1;
                    r_state    <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
